// File: rtl/lfsr_pkg.sv
// ============================================================================
// lfsr_pkg : shared constants and elaboration-time mask generator for lfsr_step
// Revision : 1.0
// ============================================================================
`default_nettype none

package lfsr_pkg;

    localparam int LFSR_MAX_WIDTH      = 64;
    localparam int LFSR_MAX_DATA_WIDTH = 256;
    localparam int LFSR_MASK_WIDTH     = LFSR_MAX_WIDTH + LFSR_MAX_DATA_WIDTH;

    localparam string CFG_FIBONACCI   = "FIBONACCI";
    localparam string CFG_GALOIS      = "GALOIS";
    localparam string STYLE_LOOP      = "LOOP";
    localparam string STYLE_REDUCTION = "REDUCTION";
    localparam string STYLE_AUTO      = "AUTO";

    localparam logic [31:0] ETH_CRC32_POLY = 32'h04C11DB7;
    localparam logic [31:0] ETH_CRC32_INIT = 32'hFFFFFFFF;

    // Mask layout: bits [LFSR_MAX_WIDTH-1:0] select state_in bits,
    // bits [LFSR_MAX_WIDTH +: LFSR_MAX_DATA_WIDTH] select data_in bits.
    typedef logic [LFSR_MASK_WIDTH-1:0] lfsr_mask_t;

    // out_idx < width selects a next-state bit; width+i selects data_out[i].
    function automatic lfsr_mask_t lfsr_mask(
        input int          width,
        input logic [63:0] poly,
        input bit          galois,
        input bit          feed_forward,
        input int          data_width,
        input int          out_idx
    );
        logic [LFSR_MAX_WIDTH-1:0][LFSR_MASK_WIDTH-1:0] st;
        lfsr_mask_t fb;
        lfsr_mask_t inj;
        lfsr_mask_t dv;
        lfsr_mask_t result;
        result = '0;
        for (int i = 0; i < LFSR_MAX_WIDTH; i++) begin
            st[i] = (i < width) ? (lfsr_mask_t'(1) << i) : '0;
        end
        for (int k = 0; k < data_width; k++) begin
            dv = lfsr_mask_t'(1) << (LFSR_MAX_WIDTH + data_width - 1 - k);
            if (galois) begin
                fb  = st[width-1] ^ dv;
                inj = feed_forward ? dv : fb;
                for (int j = width - 1; j >= 1; j--) begin
                    st[j] = st[j-1] ^ (poly[j] ? inj : '0);
                end
                st[0] = inj;
            end else begin
                fb = dv ^ st[width-1];
                for (int j = 1; j < width; j++) begin
                    if (poly[j]) fb = fb ^ st[j-1];
                end
                for (int j = width - 1; j >= 1; j--) begin
                    st[j] = st[j-1];
                end
                st[0] = feed_forward ? dv : fb;
            end
            if (out_idx == width + data_width - 1 - k) result = fb;
        end
        if (out_idx < width) result = st[out_idx];
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_step.sv
// ============================================================================
// lfsr_step : parameterised LFSR/CRC next-state engine (Galois/Fibonacci).
// Optional macro LFSR_STEP_COMB_OUT_EN removes the output register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int                    LFSR_WIDTH        = 31,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY         = 31'h10000001,
    parameter string                 LFSR_CONFIG       = "FIBONACCI",
    parameter int                    LFSR_FEED_FORWARD = 0,
    parameter int                    REVERSE           = 0,
    parameter int                    DATA_WIDTH        = 8,
    parameter string                 STYLE             = "AUTO"
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [LFSR_WIDTH-1:0] state_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [LFSR_WIDTH-1:0] state_out
);

    localparam bit IS_GALOIS = (LFSR_CONFIG == CFG_GALOIS);
    localparam bit FF_BIT    = (LFSR_FEED_FORWARD != 0);
    localparam bit REV_BIT   = (REVERSE != 0);
    localparam bit USE_LOOP  = (STYLE == STYLE_LOOP);

    if (LFSR_WIDTH < 2 || LFSR_WIDTH > LFSR_MAX_WIDTH) begin : g_err_width
        $error("lfsr_step: LFSR_WIDTH out of range");
    end
    if (DATA_WIDTH < 1 || DATA_WIDTH > LFSR_MAX_DATA_WIDTH) begin : g_err_data_width
        $error("lfsr_step: DATA_WIDTH out of range");
    end
    if (LFSR_CONFIG != CFG_FIBONACCI && LFSR_CONFIG != CFG_GALOIS) begin : g_err_config
        $error("lfsr_step: unknown LFSR_CONFIG");
    end
    if (STYLE != STYLE_LOOP && STYLE != STYLE_REDUCTION && STYLE != STYLE_AUTO) begin : g_err_style
        $error("lfsr_step: unknown STYLE");
    end

    logic [DATA_WIDTH-1:0] w_data_core;
    logic [LFSR_WIDTH-1:0] w_state_core;
    logic [DATA_WIDTH-1:0] w_core_data_out;
    logic [LFSR_WIDTH-1:0] w_core_state_out;
    logic [DATA_WIDTH-1:0] data_out_d;
    logic [LFSR_WIDTH-1:0] state_out_d;

    always_comb begin
        w_data_core  = '0;
        w_state_core = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_data_core[i] = REV_BIT ? data_in[DATA_WIDTH-1-i] : data_in[i];
        end
        for (int i = 0; i < LFSR_WIDTH; i++) begin
            w_state_core[i] = REV_BIT ? state_in[LFSR_WIDTH-1-i] : state_in[i];
        end
    end

    if (USE_LOOP) begin : g_loop
        // Galois tap vector: bit 0 always receives the injected bit.
        localparam logic [LFSR_WIDTH-1:0] GALOIS_TAPS = {LFSR_POLY[LFSR_WIDTH-1:1], 1'b1};
        logic [LFSR_WIDTH-1:0] w_loop_s;
        logic [DATA_WIDTH-1:0] w_loop_o;
        logic                  w_loop_d;
        logic                  w_loop_fb;
        logic                  w_loop_in;

        always_comb begin
            w_loop_s  = w_state_core;
            w_loop_o  = '0;
            w_loop_d  = 1'b0;
            w_loop_fb = 1'b0;
            w_loop_in = 1'b0;
            for (int k = 0; k < DATA_WIDTH; k++) begin
                w_loop_d = w_data_core[DATA_WIDTH-1-k];
                if (IS_GALOIS) begin
                    w_loop_fb = w_loop_s[LFSR_WIDTH-1] ^ w_loop_d;
                    w_loop_in = FF_BIT ? w_loop_d : w_loop_fb;
                    w_loop_s  = {w_loop_s[LFSR_WIDTH-2:0], 1'b0}
                              ^ ({LFSR_WIDTH{w_loop_in}} & GALOIS_TAPS);
                end else begin
                    w_loop_fb = w_loop_d ^ w_loop_s[LFSR_WIDTH-1]
                              ^ (^(w_loop_s[LFSR_WIDTH-2:0] & LFSR_POLY[LFSR_WIDTH-1:1]));
                    w_loop_in = FF_BIT ? w_loop_d : w_loop_fb;
                    w_loop_s  = {w_loop_s[LFSR_WIDTH-2:0], w_loop_in};
                end
                w_loop_o[DATA_WIDTH-1-k] = w_loop_fb;
            end
        end

        assign w_core_state_out = w_loop_s;
        assign w_core_data_out  = w_loop_o;
    end else begin : g_reduction
        for (genvar i = 0; i < LFSR_WIDTH; i++) begin : g_state_bit
            localparam lfsr_mask_t M = lfsr_mask(LFSR_WIDTH, 64'(LFSR_POLY), IS_GALOIS,
                                                 FF_BIT, DATA_WIDTH, i);
            assign w_core_state_out[i] = (^(w_state_core & M[LFSR_WIDTH-1:0]))
                                       ^ (^(w_data_core & M[LFSR_MAX_WIDTH +: DATA_WIDTH]));
        end
        for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_data_bit
            localparam lfsr_mask_t M = lfsr_mask(LFSR_WIDTH, 64'(LFSR_POLY), IS_GALOIS,
                                                 FF_BIT, DATA_WIDTH, LFSR_WIDTH + i);
            assign w_core_data_out[i] = (^(w_state_core & M[LFSR_WIDTH-1:0]))
                                      ^ (^(w_data_core & M[LFSR_MAX_WIDTH +: DATA_WIDTH]));
        end
    end

    always_comb begin
        data_out_d  = '0;
        state_out_d = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            data_out_d[i] = REV_BIT ? w_core_data_out[DATA_WIDTH-1-i] : w_core_data_out[i];
        end
        for (int i = 0; i < LFSR_WIDTH; i++) begin
            state_out_d[i] = REV_BIT ? w_core_state_out[LFSR_WIDTH-1-i] : w_core_state_out[i];
        end
    end

`ifdef LFSR_STEP_COMB_OUT_EN
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk ^ rst;
    assign data_out  = data_out_d;
    assign state_out = state_out_d;
`else
    logic [DATA_WIDTH-1:0] data_out_q;
    logic [LFSR_WIDTH-1:0] state_out_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_q  <= '0;
            state_out_q <= '0;
        end else begin
            data_out_q  <= data_out_d;
            state_out_q <= state_out_d;
        end
    end

    assign data_out  = data_out_q;
    assign state_out = state_out_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lfsr_step.sv
// ============================================================================
// tb_lfsr_step : self-checking bench for lfsr_step (CRC-32, PRBS7, scrambler)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lfsr_step;
    import lfsr_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // CRC-32 instances (reduction and loop styles share stimulus)
    logic [31:0] crc_si;
    logic [7:0]  crc_di;
    logic [31:0] crc_so, crcl_so;
    logic [7:0]  crc_do, crcl_do;

    lfsr_step #(.LFSR_WIDTH(32), .LFSR_POLY(32'h04C11DB7), .LFSR_CONFIG("GALOIS"),
                .LFSR_FEED_FORWARD(0), .REVERSE(1), .DATA_WIDTH(8), .STYLE("AUTO"))
        u_crc (.clk(clk), .rst(rst), .data_in(crc_di), .state_in(crc_si),
               .data_out(crc_do), .state_out(crc_so));

    lfsr_step #(.LFSR_WIDTH(32), .LFSR_POLY(32'h04C11DB7), .LFSR_CONFIG("GALOIS"),
                .LFSR_FEED_FORWARD(0), .REVERSE(1), .DATA_WIDTH(8), .STYLE("LOOP"))
        u_crc_loop (.clk(clk), .rst(rst), .data_in(crc_di), .state_in(crc_si),
                    .data_out(crcl_do), .state_out(crcl_so));

    // PRBS7 Fibonacci
    logic       prbs_di;
    logic [6:0] prbs_si, prbs_so;
    logic       prbs_do;

    lfsr_step #(.LFSR_WIDTH(7), .LFSR_POLY(7'h41), .LFSR_CONFIG("FIBONACCI"),
                .LFSR_FEED_FORWARD(0), .REVERSE(0), .DATA_WIDTH(1), .STYLE("AUTO"))
        u_prbs (.clk(clk), .rst(rst), .data_in(prbs_di), .state_in(prbs_si),
                .data_out(prbs_do), .state_out(prbs_so));

    // Scrambler / self-synchronising descrambler pair
    logic [7:0] scr_di, scr_do, dscr_di, dscr_do;
    logic [6:0] scr_si, scr_so, dscr_si, dscr_so;

    lfsr_step #(.LFSR_WIDTH(7), .LFSR_POLY(7'h41), .LFSR_CONFIG("FIBONACCI"),
                .LFSR_FEED_FORWARD(0), .REVERSE(0), .DATA_WIDTH(8), .STYLE("AUTO"))
        u_scr (.clk(clk), .rst(rst), .data_in(scr_di), .state_in(scr_si),
               .data_out(scr_do), .state_out(scr_so));

    lfsr_step #(.LFSR_WIDTH(7), .LFSR_POLY(7'h41), .LFSR_CONFIG("FIBONACCI"),
                .LFSR_FEED_FORWARD(1), .REVERSE(0), .DATA_WIDTH(8), .STYLE("LOOP"))
        u_dscr (.clk(clk), .rst(rst), .data_in(dscr_di), .state_in(dscr_si),
                .data_out(dscr_do), .state_out(dscr_so));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reflected CRC-32 byte update; data_out bit i is the LSB of the register
    // at the moment data bit i is absorbed.
    task automatic crc_ref(input logic [31:0] s, input logic [7:0] b,
                           output logic [31:0] ns, output logic [7:0] dout);
        logic [31:0] c;
        c    = s ^ {24'h0, b};
        dout = '0;
        for (int i = 0; i < 8; i++) begin
            dout[i] = c[0];
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        ns = c;
    endtask

    task automatic step();
`ifdef LFSR_STEP_COMB_OUT_EN
        #1;
`else
        @(posedge clk);
        #1;
`endif
    endtask

    task automatic apply_crc(input logic [31:0] s, input logic [7:0] d);
        @(negedge clk);
        crc_si = s;
        crc_di = d;
        step();
    endtask

    typedef struct {
        logic [31:0] st;
        logic [7:0]  d;
        logic [31:0] exp_st;
    } crc_vec_t;

    crc_vec_t    vecs[$];
    logic [31:0] m_st, m_tmp;
    logic [7:0]  m_do;
    logic [31:0] chain;
    int          first_ret;
    int          dup;
    logic [127:0] seen;
    logic [6:0]  cur;
    logic [7:0]  sent[$];

    initial begin
        crc_si = '0; crc_di = '0;
        prbs_di = 1'b0; prbs_si = '0;
        scr_di = '0; scr_si = '0; dscr_di = '0; dscr_si = '0;

        vecs.push_back('{32'hFFFFFFFF, 8'h00, 32'h2DFD1072});
        vecs.push_back('{32'h00000000, 8'h00, 32'h00000000});
        for (int i = 0; i < 12; i++) begin
            crc_vec_t v;
            v.st = $urandom;
            v.d  = 8'($urandom);
            crc_ref(v.st, v.d, v.exp_st, m_do);
            vecs.push_back(v);
        end

`ifndef LFSR_STEP_COMB_OUT_EN
        #1 rst = 1'b1;
        #2;
        check("reset_state", {32'h0, crc_so}, 64'h0);
        check("reset_dout", {56'h0, crc_do}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
`endif

        foreach (vecs[i]) begin
            apply_crc(vecs[i].st, vecs[i].d);
            crc_ref(vecs[i].st, vecs[i].d, m_tmp, m_do);
            check("crc_state", {32'h0, crc_so}, {32'h0, vecs[i].exp_st});
            check("crc_loop_state", {32'h0, crcl_so}, {32'h0, vecs[i].exp_st});
            check("crc_dout", {56'h0, crc_do}, {56'h0, m_do});
            check("crc_loop_dout", {56'h0, crcl_do}, {56'h0, m_do});
        end

        chain = ETH_CRC32_INIT;
        for (int i = 0; i < 9; i++) begin
            apply_crc(chain, 8'h31 + 8'(i));
            chain = crc_so;
        end
        check("crc_check_123456789", {32'h0, ~chain}, {32'h0, 32'hCBF43926});

`ifndef LFSR_STEP_COMB_OUT_EN
        apply_crc(32'hFFFFFFFF, 8'h00);
        check("pre_rst_state", {32'h0, crc_so}, {32'h0, 32'h2DFD1072});
        #1 rst = 1'b1;
        #1;
        check("rst_async_state", {32'h0, crc_so}, 64'h0);
        check("rst_async_dout", {56'h0, crc_do}, 64'h0);
        rst = 1'b0;
        #1;
        check("rst_release_hold", {32'h0, crc_so}, 64'h0);
        @(posedge clk);
        #1;
        check("rst_first_result", {32'h0, crc_so}, {32'h0, 32'h2DFD1072});
`else
        @(negedge clk);
        rst = 1'b1;
        crc_si = 32'hFFFFFFFF;
        crc_di = 8'h00;
        #1;
        check("comb_rst_no_effect", {32'h0, crc_so}, {32'h0, 32'h2DFD1072});
        rst = 1'b0;
`endif

        @(negedge clk);
        prbs_si = 7'h01;
        prbs_di = 1'b0;
        step();
        check("prbs_first_step", {57'h0, prbs_so}, {57'h0, 7'h02});

        cur = 7'h01;
        first_ret = 0;
        dup = 0;
        seen = '0;
        seen[1] = 1'b1;
        for (int n = 1; n <= 140; n++) begin
            @(negedge clk);
            prbs_si = cur;
            step();
            cur = prbs_so;
            if (cur == 7'h01) begin
                first_ret = n;
                break;
            end
            if (seen[cur]) dup++;
            seen[cur] = 1'b1;
        end
        check("prbs_period", 64'(first_ret), 64'd127);
        check("prbs_no_repeat", 64'(dup), 64'd0);

`ifndef LFSR_STEP_COMB_OUT_EN
        for (int m = 0; m < 40; m++) begin
            @(negedge clk);
            scr_di  = 8'($urandom);
            sent.push_back(scr_di);
            scr_si  = (m == 0) ? 7'h5A : scr_so;
            dscr_di = scr_do;
            dscr_si = dscr_so;
            @(posedge clk);
            #1;
            if (m >= 3) check("descrambled", {56'h0, dscr_do}, {56'h0, sent[m-1]});
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
